// File: rtl/lcdg_bus_sequencer_if.sv
// Command handshake between a host and the KS0108 bus sequencer.
// The host side uses the master modport and the sequencer uses the slave modport.
interface lcdg_bus_sequencer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_di;
  logic [1:0] cmd_side;
  logic [7:0] cmd_data;
  logic       init_done;

  modport master (
    output cmd_valid, cmd_di, cmd_side, cmd_data,
    input  cmd_ready, init_done
  );

  modport slave (
    input  cmd_valid, cmd_di, cmd_side, cmd_data,
    output cmd_ready, init_done
  );
endinterface

// File: rtl/lcdg_bus_sequencer.sv
// Write-only KS0108 dual-controller LCD bus sequencer with power-on reset pulse and
// programmable setup/strobe/hold timing. Define LCDG_INIT_SEQ_EN for the built-in init writes.
module lcdg_bus_sequencer #(
  parameter int SETUP_CYC   = 4,
  parameter int EN_HIGH_CYC = 25,
  parameter int HOLD_CYC    = 25,
  parameter int RST_CYC     = 500
) (
  input  logic                 clk,
  input  logic                 rst,
  lcdg_bus_sequencer_if.slave  cmd,
  output logic [7:0]           db_o,
  output logic                 dori_o,
  output logic                 rw_o,
  output logic                 en_o,
  output logic                 cs1_o,
  output logic                 cs2_o,
  output logic                 rst_o
);

  localparam int MAX_SE  = (SETUP_CYC > EN_HIGH_CYC) ? SETUP_CYC : EN_HIGH_CYC;
  localparam int MAX_HR  = (HOLD_CYC > RST_CYC) ? HOLD_CYC : RST_CYC;
  localparam int MAX_CYC = (MAX_SE > MAX_HR) ? MAX_SE : MAX_HR;
  localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t SETUP_LAST = cnt_t'(SETUP_CYC - 1);
  localparam cnt_t EN_LAST    = cnt_t'(EN_HIGH_CYC - 1);
  localparam cnt_t HOLD_LAST  = cnt_t'(HOLD_CYC - 1);
  localparam cnt_t RST_LAST   = cnt_t'(RST_CYC - 1);

  typedef enum logic [2:0] {
    RST_HOLD,
    RST_WAIT,
`ifdef LCDG_INIT_SEQ_EN
    INIT,
`endif
    IDLE,
    SETUP,
    STROBE,
    HOLD
  } state_t;

  state_t     state_q, state_d;
  cnt_t       cnt_q, cnt_d;
  logic [7:0] db_q, db_d;
  logic       di_q, di_d;
  logic       cs1_q, cs1_d;
  logic       cs2_q, cs2_d;
  logic       en_q, en_d;
  logic       rstn_q, rstn_d;
  logic       done_q, done_d;

`ifdef LCDG_INIT_SEQ_EN
  logic [1:0] idx_q, idx_d;

  function automatic logic [7:0] initByte(input logic [1:0] i);
    case (i)
      2'd0:    initByte = 8'h3F;
      2'd1:    initByte = 8'hC0;
      2'd2:    initByte = 8'hB8;
      default: initByte = 8'h40;
    endcase
  endfunction
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RST_HOLD;
      cnt_q   <= '0;
      db_q    <= '0;
      di_q    <= 1'b0;
      cs1_q   <= 1'b0;
      cs2_q   <= 1'b0;
      en_q    <= 1'b0;
      rstn_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef LCDG_INIT_SEQ_EN
      idx_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      db_q    <= db_d;
      di_q    <= di_d;
      cs1_q   <= cs1_d;
      cs2_q   <= cs2_d;
      en_q    <= en_d;
      rstn_q  <= rstn_d;
      done_q  <= done_d;
`ifdef LCDG_INIT_SEQ_EN
      idx_q   <= idx_d;
`endif
    end
  end

  // The counter reloads to zero on every state change; bus fields load only when a write starts.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + cnt_t'(1);
    db_d    = db_q;
    di_d    = di_q;
    cs1_d   = cs1_q;
    cs2_d   = cs2_q;
`ifdef LCDG_INIT_SEQ_EN
    idx_d   = idx_q;
`endif
    case (state_q)
      RST_HOLD: begin
        if (cnt_q == RST_LAST) begin
          state_d = RST_WAIT;
          cnt_d   = '0;
        end
      end
      RST_WAIT: begin
        if (cnt_q == RST_LAST) begin
`ifdef LCDG_INIT_SEQ_EN
          state_d = INIT;
`else
          state_d = IDLE;
`endif
          cnt_d   = '0;
        end
      end
`ifdef LCDG_INIT_SEQ_EN
      INIT: begin
        state_d = SETUP;
        cnt_d   = '0;
        db_d    = initByte(idx_q);
        di_d    = 1'b0;
        cs1_d   = 1'b1;
        cs2_d   = 1'b1;
      end
`endif
      IDLE: begin
        cnt_d = '0;
        if (cmd.cmd_valid && (cmd.cmd_side != 2'b00)) begin
          state_d = SETUP;
          db_d    = cmd.cmd_data;
          di_d    = cmd.cmd_di;
          cs1_d   = cmd.cmd_side[0];
          cs2_d   = cmd.cmd_side[1];
        end
      end
      SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          state_d = STROBE;
          cnt_d   = '0;
        end
      end
      STROBE: begin
        if (cnt_q == EN_LAST) begin
          state_d = HOLD;
          cnt_d   = '0;
        end
      end
      HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          cnt_d   = '0;
          cs1_d   = 1'b0;
          cs2_d   = 1'b0;
          state_d = IDLE;
`ifdef LCDG_INIT_SEQ_EN
          if (!done_q) begin
            idx_d   = idx_q + 2'd1;
            state_d = (idx_q == 2'd3) ? IDLE : INIT;
          end
`endif
        end
      end
      default: begin
        state_d = RST_HOLD;
        cnt_d   = '0;
      end
    endcase
  end

  // Strobe, reset and done flags are registered from the next state so they change cleanly.
  always_comb begin
    en_d   = (state_d == STROBE);
    rstn_d = (state_d != RST_HOLD);
    done_d = done_q | (state_d == IDLE);
  end

  assign cmd.cmd_ready = (state_q == IDLE);
  assign cmd.init_done = done_q;
  assign db_o          = db_q;
  assign dori_o        = di_q;
  assign rw_o          = 1'b0;
  assign en_o          = en_q;
  assign cs1_o         = cs1_q;
  assign cs2_o         = cs2_q;
  assign rst_o         = rstn_q;

endmodule

// File: doc/lcdg_bus_sequencer.md
Name: lcdg_bus_sequencer

Overview:
Write-only bus sequencer for the KS0108-style dual-controller 128x64 graphic LCD.
- Accepts byte commands over a valid/ready handshake.
- Generates the LCD power-on reset pulse.
- Emits DB/DI/RW/EN/CS1/CS2/RST with programmable setup, enable-high and hold timing.
- Outputs drive the *_i inputs of the registered LCD pin-output stage, which sits directly downstream.

Parameters:
SETUP_CYC, 4, cycles DB/DI/CS are stable before EN rises (tAS); must be >=1
EN_HIGH_CYC, 25, cycles EN is held high (tWH); must be >=1
HOLD_CYC, 25, cycles EN is low with DB/DI/CS still held after EN falls (tDH + tWL); must be >=1
RST_CYC, 500, cycles for each of the two reset phases (rst_o low, then recovery wait); must be >=1

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
cmd_valid  input  1  command present
cmd_ready  output  1  sequencer can accept a command this cycle
cmd_di  input  1  1 = display data, 0 = instruction
cmd_side  input  2  bit0 selects CS1 (left half), bit1 selects CS2 (right half)
cmd_data  input  8  byte to write
init_done  output  1  power-up sequence complete; stays 1 until rst
db_o  output  8  LCD data bus
dori_o  output  1  LCD D/I line
rw_o  output  1  LCD R/W line, constant 0 (write only)
en_o  output  1  LCD enable strobe
cs1_o  output  1  chip select left, active high
cs2_o  output  1  chip select right, active high
rst_o  output  1  LCD reset, active low

Behaviour:
- Reset (asynchronous, rst=1):
  - db_o=0, dori_o=0, rw_o=0, en_o=0, cs1_o=0, cs2_o=0, rst_o=0.
  - cmd_ready=0, init_done=0, all counters 0, state RST_HOLD.
  - Assertion mid-transaction aborts it immediately; en_o drops in the same instant.
- States:
  - RST_HOLD: rst_o=0 for RST_CYC cycles -> RST_WAIT.
  - RST_WAIT: rst_o=1 for RST_CYC cycles -> INIT, or IDLE when the feature is off.
  - IDLE: cmd_ready=1; init_done=1 from the first IDLE cycle onward.
  - SETUP: SETUP_CYC cycles, en_o=0.
  - STROBE: EN_HIGH_CYC cycles, en_o=1.
  - HOLD: HOLD_CYC cycles, en_o=0 -> IDLE (or back to INIT while the init sequence runs).
- Handshake:
  - Accept in cycle T when cmd_valid & cmd_ready.
  - cmd_* captured at T. db_o/dori_o/cs1_o/cs2_o take the captured values at T+1.
  - en_o is high in cycles T+1+SETUP_CYC .. T+SETUP_CYC+EN_HIGH_CYC.
  - cmd_ready returns at T+1+SETUP_CYC+EN_HIGH_CYC+HOLD_CYC.
  - Back-to-back period = SETUP_CYC+EN_HIGH_CYC+HOLD_CYC+1 cycles.
- cmd_ready is 0 outside IDLE. cmd_valid is ignored there, and cmd_* may change freely.
- db_o, dori_o, cs1_o, cs2_o stay constant from T+1 through the last HOLD cycle. No glitch is allowed while en_o=1.
- Returning to IDLE: cs1_o=cs2_o=0; db_o and dori_o keep their last values.
- cmd_side=2'b00: command is accepted, no bus activity, cmd_ready high again at T+1.
- cmd_side=2'b11: both chips written in a single strobe.
- rw_o is tied to 0 in every state.
- Counters are sized to the largest parameter (clog2). Each counter reloads on every state entry.

Optional Feature:
LCDG_INIT_SEQ_EN
- Defined: after RST_WAIT the sequencer enters INIT and issues four internal instruction writes (cmd_di=0, cmd_side=2'b11), each with full SETUP/STROBE/HOLD timing, in this order:
  - 0x3F (display on)
  - 0xC0 (start line 0)
  - 0xB8 (page 0)
  - 0x40 (column 0)
  - Then -> IDLE, init_done=1.
  - cmd_ready stays 0 throughout the sequence.
- Undefined: the INIT state is absent; RST_WAIT -> IDLE directly.

Test Plan:
Bench parameters: SETUP_CYC=2, EN_HIGH_CYC=3, HOLD_CYC=2, RST_CYC=10.
- Power-up: rst pulse, then release -> rst_o=0 for 10 cycles, then 1. With the feature off: init_done=1 and cmd_ready=1 exactly 20 cycles after release.
- Single write: data 0xA5, di=1, side=01 accepted at T -> db_o=0xA5, dori_o=1, cs1_o=1, cs2_o=0 at T+1; en_o high T+3..T+5; cmd_ready high again at T+8; rw_o=0 throughout.
- Back-to-back: cmd_valid held with 0x11 then 0x22 -> second acceptance exactly 8 cycles after the first; db_o changes only while en_o=0.
- Side 00 and side 11: side=00 -> no en_o pulse, ready at T+1. Side=11 with data 0x3F -> cs1_o=cs2_o=1 during a single strobe.
- Reset mid-strobe: rst asserted while en_o=1 -> all outputs return to reset values immediately; the full reset sequence reruns after release.
- LCDG_INIT_SEQ_EN defined: after the reset phases, exactly four en_o pulses carry 0x3F, 0xC0, 0xB8, 0x40 with dori_o=0, cs1_o=cs2_o=1. Then init_done=1 and cmd_ready=1.
